board_link_ctrl: RTL and testbench
==================================

// Module: board_link_ctrl
// PURPOSE
//  Conditions the inter-board link pins for two-player mode. Sits between the raw
//  receive_*/send_* pins and the stage FSM: synchronises and glitch-filters the
//  three peer inputs, emits clean levels and one-cycle event pulses, and stretches
//  local start requests into a fixed-width pulse the peer board can reliably sample.
// PARAMETERS
//  SYNC_STAGES    2       flip-flops per input synchroniser (>=2)
//  FILTER_CYCLES  1000    consecutive stable cycles before a filtered input changes (>=1)
//  HOLD_CYCLES    100000  send_start high time, then enforced low gap, in clk cycles (>=2)
// PORTS
//  clk                input   1  system clock (100 MHz)
//  rst                input   1  synchronous, active-high reset
//  receive_connect    input   1  raw peer connect pin (asynchronous)
//  receive_start      input   1  raw peer start pin (asynchronous)
//  receive_game_finish input  1  raw peer finish pin (asynchronous)
//  tx_connect_req     input   1  local connect level from stage FSM
//  tx_start_req       input   1  local start request, 1-cycle pulse
//  tx_finish_req      input   1  local game-finish level (board solved)
//  send_connect       output  1  registered connect pin to peer
//  send_start         output  1  stretched start pin to peer
//  send_game_finish   output  1  registered finish pin to peer
//  peer_connected     output  1  filtered receive_connect level
//  peer_start_pulse   output  1  1-cycle pulse on filtered receive_start rising edge
//  peer_finish_pulse  output  1  1-cycle pulse on filtered receive_game_finish rising edge
//  link_up            output  1  send_connect & peer_connected, registered
//  link_lost_pulse    output  1  1-cycle pulse when link_up falls while tx_connect_req=1
//  start_busy         output  1  start FSM not in IDLE
// BEHAVIOUR
//  - Reset: every output 0; synchronisers, filters, counters, pending flag cleared;
//    start FSM -> IDLE. Reset mid-hold drops send_start in the next cycle.
//  - RX path, per input: SYNC_STAGES flops, then filter. Filter counter clears when sync
//    value == filtered value; else increments; when it reaches FILTER_CYCLES-1 while
//    still differing, filtered value flips next edge and counter clears. Glitch shorter
//    than FILTER_CYCLES cycles -> no change. Pin-to-level latency SYNC_STAGES+FILTER_CYCLES.
//  - Event pulses are asserted in the same cycle the filtered level goes 0->1; falling
//    edges produce no pulse. Counter width $clog2(FILTER_CYCLES+1), saturating, no wrap.
//  - send_connect, send_game_finish: tx_*_req registered, 1-cycle latency, no filtering.
//  - link_up registered from send_connect & peer_connected; link_lost_pulse fires the cycle
//    link_up goes 1->0 only if tx_connect_req is still 1 (local disconnect is silent).
//  - Start FSM: IDLE --tx_start_req--> HOLD (send_start=1 from next cycle, HOLD_CYCLES
//    cycles) -> GAP (send_start=0, HOLD_CYCLES cycles) -> IDLE.
//    tx_start_req during HOLD: ignored. During GAP: sets one-deep pending flag; further
//    requests while pending are merged. GAP exit with pending -> HOLD directly, flag cleared.
//    Request in the same cycle GAP ends counts as pending (one extra pulse).
//  - Hold counter width $clog2(HOLD_CYCLES+1); counter restarts at 0 on every state entry.
//  - Pins of both directions are independent; simultaneous rx events on all three lines
//    each yield their own pulse in the same cycle.
// TESTING (FILTER_CYCLES=4, HOLD_CYCLES=8, SYNC_STAGES=2)
//  - rst held 3 cycles with all pins 1 -> all outputs 0; release, pins stable -> peer_connected
//    rises 6 cycles later, peer_start_pulse and peer_finish_pulse each high exactly 1 cycle.
//  - receive_start 3-cycle glitch -> no peer_start_pulse; 4-cycle high -> exactly one pulse.
//  - tx_start_req pulse at cycle t -> send_start high cycles t+1..t+8, low t+9..t+16,
//    start_busy high t+1..t+16; second req at t+4 -> no extra pulse.
//  - req at t+12 (in GAP) -> send_start high again t+17..t+24; two reqs in GAP -> one pulse.
//  - tx_connect_req=1, peer_connected 1->0 -> link_up falls, link_lost_pulse 1 cycle; repeat with
//    tx_connect_req dropped first -> link_up falls, no link_lost_pulse.
//  - rst asserted mid-HOLD -> send_start=0 and start_busy=0 next cycle; pending flag cleared.

Source files
------------

// File: rtl/board_link_ctrl.sv
// board_link_ctrl
//   Conditions the inter-board link pins for two-player mode. The three raw peer
//   inputs are synchronised and glitch-filtered into clean levels plus rising-edge
//   event pulses. Local connect/finish levels are registered out to the peer, and
//   local start requests are stretched into a fixed-width pulse followed by an
//   enforced low gap so the peer board can reliably sample it.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   receive_connect       raw peer connect pin (asynchronous)
//   receive_start         raw peer start pin (asynchronous)
//   receive_game_finish   raw peer finish pin (asynchronous)
//   tx_connect_req        local connect level
//   tx_start_req          local start request, 1-cycle pulse
//   tx_finish_req         local game-finish level
//   send_connect          registered connect pin to peer
//   send_start            stretched start pin to peer
//   send_game_finish      registered finish pin to peer
//   peer_connected        filtered receive_connect level
//   peer_start_pulse      1-cycle pulse on filtered receive_start rising edge
//   peer_finish_pulse     1-cycle pulse on filtered receive_game_finish rising edge
//   link_up               send_connect & peer_connected, registered
//   link_lost_pulse       1-cycle pulse when link_up falls while tx_connect_req is high
//   start_busy            start pulse generator not idle

module board_link_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES   = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic receive_connect,
  input  logic receive_start,
  input  logic receive_game_finish,
  input  logic tx_connect_req,
  input  logic tx_start_req,
  input  logic tx_finish_req,
  output logic send_connect,
  output logic send_start,
  output logic send_game_finish,
  output logic peer_connected,
  output logic peer_start_pulse,
  output logic peer_finish_pulse,
  output logic link_up,
  output logic link_lost_pulse,
  output logic start_busy
);

  localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);
  localparam logic [FiltW-1:0] FiltMax  = {FiltW{1'b1}};
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = {HoldW{1'b1}};

  // ---------------------------------------------------------------------------
  // RX path: index 0 = connect, 1 = start, 2 = game finish
  // ---------------------------------------------------------------------------
  logic [2:0] rx_raw;
  logic [2:0] rx_level;
  logic [2:0] rx_pulse;

  assign rx_raw = {receive_game_finish, receive_start, receive_connect};

  for (genvar i = 0; i < 3; i++) begin : g_rx
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FiltW-1:0]       cnt_q;
    logic                   level_q;
    logic                   pulse_q;
    logic                   sync_val;
    logic                   flip;

    assign sync_val = sync_q[SYNC_STAGES-1];
    // The filtered level only moves after FILTER_CYCLES consecutive differing samples.
    assign flip     = (sync_val != level_q) && (cnt_q == FiltLast);

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_raw[i]};
        // Pulse lines up with the cycle the filtered level first reads 1.
        pulse_q <= flip & ~level_q;
        if (sync_val == level_q) begin
          cnt_q <= '0;
        end else if (flip) begin
          level_q <= ~level_q;
          cnt_q   <= '0;
        end else if (cnt_q != FiltMax) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign rx_level[i] = level_q;
    assign rx_pulse[i] = pulse_q;
  end

  assign peer_connected    = rx_level[0];
  assign peer_start_pulse  = rx_pulse[1];
  assign peer_finish_pulse = rx_pulse[2];

  // ---------------------------------------------------------------------------
  // TX levels and link status
  // ---------------------------------------------------------------------------
  logic send_connect_q;
  logic send_finish_q;
  logic link_up_q;
  logic link_lost_q;
  logic link_up_d;

  assign link_up_d = send_connect_q & rx_level[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      send_connect_q <= 1'b0;
      send_finish_q  <= 1'b0;
      link_up_q      <= 1'b0;
      link_lost_q    <= 1'b0;
    end else begin
      send_connect_q <= tx_connect_req;
      send_finish_q  <= tx_finish_req;
      link_up_q      <= link_up_d;
      // A drop caused by our own disconnect is expected, so it is not reported.
      link_lost_q    <= link_up_q & ~link_up_d & tx_connect_req;
    end
  end

  assign send_connect     = send_connect_q;
  assign send_game_finish = send_finish_q;
  assign link_up          = link_up_q;
  assign link_lost_pulse  = link_lost_q;

  // ---------------------------------------------------------------------------
  // Start pulse stretcher: IDLE -> HOLD (pin high) -> GAP (pin low) -> IDLE
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StHold, StGap} start_state_e;

  start_state_e     state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             pending_q, pending_d;
  logic             hold_last;

  assign hold_last = (hold_cnt_q == HoldLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (tx_start_req) state_d = StHold;
      end
      StHold: begin
        // Requests during the high phase are dropped.
        if (hold_last) state_d = StGap;
      end
      StGap: begin
        if (hold_last) begin
          // A request on the final gap cycle still earns another pulse.
          state_d   = (pending_q || tx_start_req) ? StHold : StIdle;
          pending_d = 1'b0;
        end else if (tx_start_req) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_d != state_q) || (state_q == StIdle)) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  always_comb begin
    send_start = (state_q == StHold);
    start_busy = (state_q != StIdle);
  end

endmodule

// File: tb/tb_board_link_ctrl.sv
module tb_board_link_ctrl;

  localparam int S = 2;
  localparam int F = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  logic receive_connect, receive_start, receive_game_finish;
  logic tx_connect_req, tx_start_req, tx_finish_req;
  logic send_connect, send_start, send_game_finish;
  logic peer_connected, peer_start_pulse, peer_finish_pulse;
  logic link_up, link_lost_pulse, start_busy;

  always #5 clk = ~clk;

  board_link_ctrl #(
    .SYNC_STAGES  (S),
    .FILTER_CYCLES(F),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .receive_connect    (receive_connect),
    .receive_start      (receive_start),
    .receive_game_finish(receive_game_finish),
    .tx_connect_req     (tx_connect_req),
    .tx_start_req       (tx_start_req),
    .tx_finish_req      (tx_finish_req),
    .send_connect       (send_connect),
    .send_start         (send_start),
    .send_game_finish   (send_game_finish),
    .peer_connected     (peer_connected),
    .peer_start_pulse   (peer_start_pulse),
    .peer_finish_pulse  (peer_finish_pulse),
    .link_up            (link_up),
    .link_lost_pulse    (link_lost_pulse),
    .start_busy         (start_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state. Edge index e counts every clock edge driven by step().
  int e = 0;
  bit m_pin[3][$];
  bit m_sync[3][$];
  bit m_lvl[3];
  bit m_pls[3];
  bit m_sc, m_sf, m_lu, m_ll;
  int hs;      // edge at which the latest start window began
  bit pend;

  logic [2:0] cur_rx, cur_tx;

  // Output order: send_connect, send_start, send_game_finish, peer_connected,
  // peer_start_pulse, peer_finish_pulse, link_up, link_lost_pulse, start_busy
  function automatic logic [8:0] dut_out();
    return {send_connect, send_start, send_game_finish, peer_connected, peer_start_pulse,
            peer_finish_pulse, link_up, link_lost_pulse, start_busy};
  endfunction

  function automatic logic [8:0] model_out();
    bit hi, busy;
    hi   = (e >= hs) && (e <= hs + H - 1);
    busy = (e >= hs) && (e <= hs + 2 * H - 1);
    return {m_sc, hi, m_sf, m_lvl[0], m_pls[1], m_pls[2], m_lu, m_ll, busy};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, e, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [2:0] rx, input logic [2:0] tx);
    bit new_lu, sv, all_diff;
    int n;
    if (r) begin
      for (int c = 0; c < 3; c++) begin
        m_pin[c].delete();
        m_sync[c].delete();
        m_lvl[c] = 1'b0;
        m_pls[c] = 1'b0;
      end
      m_sc = 1'b0; m_sf = 1'b0; m_lu = 1'b0; m_ll = 1'b0;
      hs   = -100000;
      pend = 1'b0;
      return;
    end
    new_lu = m_sc & m_lvl[0];
    m_ll   = m_lu & !new_lu & tx[0];
    m_lu   = new_lu;
    m_sc   = tx[0];
    m_sf   = tx[2];
    // Level flips once the last F synchronised samples all disagree with it.
    for (int c = 0; c < 3; c++) begin
      m_pin[c].push_back(rx[c]);
      n  = m_pin[c].size();
      sv = (n > S) ? m_pin[c][n-1-S] : 1'b0;
      m_sync[c].push_back(sv);
      n = m_sync[c].size();
      all_diff = (n >= F);
      for (int j = 0; j < F; j++)
        if (all_diff && m_sync[c][n-1-j] == m_lvl[c]) all_diff = 1'b0;
      m_pls[c] = all_diff && !m_lvl[c];
      if (all_diff) m_lvl[c] = !m_lvl[c];
      while (m_pin[c].size() > 32) void'(m_pin[c].pop_front());
      while (m_sync[c].size() > 32) void'(m_sync[c].pop_front());
    end
    // Start windows: H high edges then H low edges from hs.
    if (pend && e == hs + 2 * H) begin
      hs   = e;
      pend = 1'b0;
    end else if (tx[1]) begin
      if (e >= hs + 2 * H) hs = e;
      else if (e > hs + H) pend = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic [2:0] rx, input logic [2:0] tx);
    rst = r;
    {receive_game_finish, receive_start, receive_connect} = rx;
    {tx_finish_req, tx_start_req, tx_connect_req} = tx;
    @(posedge clk);
    e++;
    model_edge(r, rx, tx);
    #1;
    check("model", dut_out(), model_out());
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] rx;
    logic [2:0] tx;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int cnt;
    int hi_cnt;
    int hold_left[3];
    logic [2:0] tx_nostart;

    hs = -100000;
    pend = 1'b0;

    // Reset with all pins high, then release and watch the filtered levels arrive.
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 3'b111, 3'b111, 9'b000_000_000};
    for (int i = 3; i < 8; i++) tbl[i] = '{1'b0, 3'b111, 3'b001, 9'b100_000_000};
    tbl[8]  = '{1'b0, 3'b111, 3'b001, 9'b100_111_000};
    tbl[9]  = '{1'b0, 3'b111, 3'b001, 9'b100_100_100};
    tbl[10] = '{1'b0, 3'b111, 3'b001, 9'b100_100_100};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].rx, tbl[i].tx);
      check("table", dut_out(), tbl[i].exp);
    end
    cur_rx = 3'b111;
    cur_tx = 3'b001;

    // receive_start: 3-cycle glitch yields nothing, 4-cycle high yields one pulse.
    cur_rx = 3'b101;
    for (int i = 0; i < 10; i++) step(1'b0, cur_rx, cur_tx);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin step(1'b0, 3'b111, cur_tx); cnt += peer_start_pulse; end
    for (int i = 0; i < 10; i++) begin step(1'b0, cur_rx, cur_tx); cnt += peer_start_pulse; end
    check("glitch_no_pulse", 9'(cnt), 9'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(1'b0, 3'b111, cur_tx); cnt += peer_start_pulse; end
    for (int i = 0; i < 12; i++) begin step(1'b0, cur_rx, cur_tx); cnt += peer_start_pulse; end
    check("four_cycle_one_pulse", 9'(cnt), 9'd1);

    // Start stretching: req at 0 (HOLD repeat at 4 ignored), req at 12 in GAP.
    for (int c = 0; c < 36; c++) begin
      int n;
      step(1'b0, cur_rx, {cur_tx[2], (c == 0 || c == 4 || c == 12), cur_tx[0]});
      n = c + 1;
      check("start_seq_a", {7'd0, send_start, start_busy},
            {7'd0, ((n >= 1 && n <= 8) || (n >= 17 && n <= 24)), (n >= 1 && n <= 32)});
    end
    // Two requests in GAP merge into one extra pulse.
    for (int c = 0; c < 36; c++) begin
      int n;
      step(1'b0, cur_rx, {cur_tx[2], (c == 0 || c == 10 || c == 13), cur_tx[0]});
      n = c + 1;
      check("start_seq_b", {7'd0, send_start, start_busy},
            {7'd0, ((n >= 1 && n <= 8) || (n >= 17 && n <= 24)), (n >= 1 && n <= 32)});
    end

    // Peer drops connect while we still want the link.
    check("link_up_before", {8'd0, link_up}, 9'd1);
    cur_rx[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(1'b0, cur_rx, cur_tx); cnt += link_lost_pulse; end
    check("lost_pulse_count", 9'(cnt), 9'd1);
    check("link_down_peer", {8'd0, link_up}, 9'd0);
    cur_rx[0] = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, cur_rx, cur_tx);
    check("link_restored", {8'd0, link_up}, 9'd1);
    // Local disconnect is silent.
    cur_tx[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(1'b0, cur_rx, cur_tx); cnt += link_lost_pulse; end
    check("local_drop_silent", 9'(cnt), 9'd0);
    check("link_down_local", {8'd0, link_up}, 9'd0);

    // Reset in the middle of HOLD.
    tx_nostart = cur_tx & 3'b101;
    step(1'b0, cur_rx, tx_nostart | 3'b010);
    for (int i = 0; i < 3; i++) step(1'b0, cur_rx, tx_nostart);
    check("hold_before_rst", {7'd0, send_start, start_busy}, 9'b11);
    step(1'b1, cur_rx, tx_nostart);
    check("hold_after_rst", {7'd0, send_start, start_busy}, 9'b00);
    for (int i = 0; i < 10; i++) step(1'b0, cur_rx, tx_nostart);

    // Reset while a request is pending in GAP: no pulse afterwards.
    for (int c = 0; c < 12; c++)
      step(1'b0, cur_rx, tx_nostart | ((c == 0 || c == 10) ? 3'b010 : 3'b000));
    step(1'b1, cur_rx, tx_nostart);
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin step(1'b0, cur_rx, tx_nostart); hi_cnt += send_start; end
    check("pending_cleared", 9'(hi_cnt), 9'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3; c++) hold_left[c] = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r;
      for (int c = 0; c < 3; c++) begin
        if (hold_left[c] == 0) begin
          cur_rx[c]    = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 8);
        end
        hold_left[c]--;
      end
      if ($urandom_range(0, 19) == 0) cur_tx[0] = ~cur_tx[0];
      if ($urandom_range(0, 29) == 0) cur_tx[2] = ~cur_tx[2];
      cur_tx[1] = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 599) == 0);
      step(r, cur_rx, cur_tx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
